// File: rtl/mux8_scan_pkg.sv
// Shared types and helpers for the 8:1 mux scan sequencer.
// Holds the FSM state enum, channel sizing and channel-pick functions.
package mux8_scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest set mask bit at or above channel 0.
  function automatic ch_pick_t first_ch(
    input logic [NCH-1:0] mask
  );
    ch_pick_t r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.vld = 1'b1;
        r.ch  = SEL_W'(i);
      end
    end
    return r;
  endfunction

  // Lowest set mask bit strictly above cur.
  function automatic ch_pick_t next_ch(
    input logic [NCH-1:0]   mask,
    input logic [SEL_W-1:0] cur
  );
    ch_pick_t r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.vld = 1'b1;
        r.ch  = SEL_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux8_settle_timer.sv
// Loadable 4-bit down-counter timing the strobe settle window.
// Ports: clk/rst, clr (abort), load+load_val, en (count), zero flag.
module mux8_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Serial scan sequencer for the shared 8:1 strobed inverting mux.
// Ports: start/abort/ch_mask in, sel_pad/strobe_n to mux, mux_m/mux_n back, data/done/busy/err out.
module mux8_scan_ctrl
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int NCH    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [NCH-1:0] ch_mask,
  output logic [2:0]     sel_pad,
  output logic           strobe_n,
  input  logic           mux_m,
  input  logic           mux_n,
  output logic [NCH-1:0] data,
  output logic           done,
  output logic           busy,
  output logic           err
);

  state_e         state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [2:0]     sel_q, sel_d;
  logic [NCH-1:0] data_q, data_d;
  logic           err_q, err_d;

  logic           t_load;
  logic           t_en;
  logic           t_zero;
  ch_pick_t       pick;

  mux8_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (abort),
    .load     (t_load),
    .en       (t_en),
    .load_val (4'(SETTLE - 1)),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = err_q;
    t_load  = 1'b0;
    t_en    = 1'b0;
    pick    = '0;
    if (abort) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mask_d = ch_mask;
            err_d  = 1'b0;
            pick   = first_ch(ch_mask);
            if (pick.vld) begin
              // Empty mask leaves data alone; otherwise start clean.
              data_d  = '0;
              sel_d   = pick.ch;
              state_d = SETUP;
            end else begin
              state_d = DONE;
            end
          end
        end
        SETUP: begin
          // A disabled mux must drive m low.
          if (mux_m) begin
            err_d = 1'b1;
          end
          t_load  = 1'b1;
          state_d = STROBE;
        end
        STROBE: begin
          t_en = 1'b1;
          if (t_zero) begin
            data_d[sel_q] = ~mux_m;
            if (mux_n == mux_m) begin
              err_d = 1'b1;
            end
            // Next-channel decision folded into the strobe exit.
            pick = next_ch(mask_q, sel_q);
            if (pick.vld) begin
              sel_d   = pick.ch;
              state_d = SETUP;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign sel_pad  = sel_q;
  assign strobe_n = (state_q != STROBE);
  assign data     = data_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Sequencer for the 8:1 strobed, inverting mux datapath. Inputs a..h are selected by {k,j,i}. l is an active-low strobe. Outputs: m = ~l & ~sel_data, n = ~m.
- Drives the select and strobe lines, waits a settle time per channel and samples the mux outputs.
- Assembles the 8 sampled channels into one word with a start/done handshake.
- Sits between the pad-level mux and the register/control fabric. Lets one shared mux be read serially instead of duplicating the datapath.

Parameters:
- SETTLE, 2, strobe-active cycles per channel before sampling; legal 1..15.
- NCH, 8, channel count; fixed at 8 (select width 3).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; accepted only in IDLE.
- abort  in  1  stop the current scan and return to IDLE with no done pulse.
- ch_mask  in  8  bit c=1 means scan channel c; sampled at start acceptance.
- sel_pad  out  3  to mux select {k,j,i}; channel index c maps to a=0 .. h=7.
- strobe_n  out  1  to mux l; 0 = mux enabled.
- mux_m  in  1  mux m output.
- mux_n  in  1  mux n output.
- data  out  8  captured word; data[c] = sampled value of channel c.
- done  out  1  one-cycle pulse when a scan completes; data is valid the same cycle.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared on start acceptance or rst.

Behaviour:
- Reset values: sel_pad=0, strobe_n=1, data=0, done=0, busy=0, err=0. FSM goes to IDLE. Reset mid-scan discards everything.
- States: IDLE, SETUP, STROBE, NEXT, DONE.
- IDLE, start=1:
  - Latch ch_mask and clear err.
  - Find the lowest set mask bit. If mask==0, go directly to DONE; data is left unchanged.
  - Otherwise set sel_pad to that channel and go to SETUP.
- SETUP (1 cycle):
  - strobe_n=1; sel_pad is stable.
  - Check mux_m==0 (disabled mux must output 0). Otherwise set err.
  - Go to STROBE and load the settle counter with SETTLE-1.
- STROBE:
  - strobe_n=0; count down.
  - On count==0:
    - Capture data[sel_pad] <= ~mux_m.
    - If mux_n != ~mux_m, set err.
    - Go to NEXT.
- NEXT (0-cycle decision, folded into the STROBE exit edge):
  - If a higher masked channel remains, set sel_pad to the next set bit and go to SETUP.
  - Else go to DONE.
  - strobe_n returns to 1 on the transition.
- DONE (1 cycle):
  - done=1, busy=0 next cycle, return to IDLE.
  - A start in the DONE cycle is ignored.
- Masked-off channels: never selected, take zero cycles, and their data bits are cleared to 0 at start acceptance.
- Latency from start acceptance to the done pulse: popcount(mask)*(1+SETTLE)+1 cycles. Full mask with SETTLE=2 gives 25.
- start while busy: ignored, no queuing.
- abort: takes priority over every transition.
  - Next cycle: IDLE, strobe_n=1, sel_pad=0, no done.
  - data keeps bits already captured; other bits keep 0.
- abort and start together in IDLE: abort wins and start is dropped.
- sel_pad changes only while strobe_n=1, never in the same cycle strobe_n falls (glitch-free select).

Decomposition:
- Package mux8_scan_pkg holds:
  - state enum {IDLE, SETUP, STROBE, DONE};
  - NCH=8 and SEL_W=3;
  - a function next_ch(mask, cur), returning the lowest set bit above cur plus a valid flag.
- One sub-module, mux8_settle_timer: 4-bit loadable down-counter with a zero flag, clear on rst/abort.
- All other logic lives in mux8_scan_ctrl.

Test Plan:
- Mux model with inputs a..h = 8'b1010_0110 (h..a), mask=8'hFF, SETTLE=2 -> done at cycle 25 after start, data=8'hA6, err=0. sel_pad steps 0..7, strobe_n low 2 cycles per channel.
- mask=8'h81, same inputs -> only channels 0 and 7 visited; done at cycle 7; data=8'h80 (a=0, h=1, others 0).
- mask=8'h00 -> done on the cycle after acceptance; busy 1 cycle; data unchanged.
- abort in the third STROBE cycle of a full scan -> next cycle strobe_n=1, sel_pad=0, busy=0, no done. data holds channels 0..1 only. A new start then completes normally.
- Model forces mux_n=mux_m on channel 3 -> err=1 at the end, data still captured. The next start clears err.
- start pulsed while busy, and rst asserted mid-STROBE -> extra start ignored, done count stays 1. rst returns all outputs to reset values the next cycle.
